// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the core load/store path and data_mem_ctrl.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory stage: one load/store at a time into a word RAM, with byte/half
// read-modify-write, load sign/zero extension and misalignment rejection.
//
// state | meaning
// IDLE  | ready for a request
// RD    | RAM word captured into rdbuf at end of cycle
// WR    | merged word written to RAM at end of cycle
// RSP   | one-cycle response pulse
module data_mem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_ctrl_if.slave bus
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;

  state_t            state_q, state_d;
  logic              we_q, err_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdbuf_q;
  logic [31:0]       mem_q [DEPTH];

  logic              accept, req_err;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        off;
  logic [31:0]       wr_word, ld_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign accept = bus.req_valid && (state_q == S_IDLE);
  assign idx    = addr_q[ADDR_W-1:2];
  assign off    = addr_q[1:0];

  always_comb begin
    req_err = 1'b1;
    case (bus.req_size)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = bus.req_addr[0];
      3'b010:  req_err = (bus.req_addr[1:0] != 2'b00);
      3'b100:  req_err = bus.req_we;
      3'b101:  req_err = bus.req_we || bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                                state_d = S_RSP;
          else if (bus.req_we && bus.req_size == 3'b010) state_d = S_WR;
          else                                        state_d = S_RD;
        end
      end
      S_RD:    state_d = we_q ? S_WR : S_RSP;
      S_WR:    state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdbuf_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        err_q   <= req_err;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == S_RD) rdbuf_q <= mem_q[idx];
    end
  end

  // Reset wins over the write so a store interrupted in WR leaves RAM intact.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_WR) mem_q[idx] <= wr_word;
  end

  always_comb begin
    wr_word = rdbuf_q;
    case (size_q[1:0])
      2'b00:   wr_word[{off, 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (off[1]) wr_word[31:16] = wdata_q[15:0];
        else        wr_word[15:0]  = wdata_q[15:0];
      end
      default: wr_word = wdata_q;
    endcase
  end

  assign ld_byte = rdbuf_q[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? rdbuf_q[31:16] : rdbuf_q[15:0];

  always_comb begin
    ld_data = rdbuf_q;
    case (size_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = rdbuf_q;
    endcase
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RSP);
  assign bus.rsp_err   = (state_q == S_RSP) && err_q;
  assign bus.rsp_rdata = ((state_q == S_RSP) && !err_q && !we_q) ? ld_data : 32'b0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised bench for data_mem_ctrl with a byte-level memory model and a
// per-cycle compare of the handshake and response outputs.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(8)) bus ();
  data_mem_ctrl #(.ADDR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rst = -1;
  bit done = 1'b0;

  bit          pend = 1'b0;
  int          acc = 0;
  int          rsp_cyc = 0;
  bit          exp_err = 1'b0;
  logic [31:0] exp_data = '0;
  logic [31:0] mdl [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what a request should do, from access size and alignment rules.
  function automatic void model(input bit we, input logic [2:0] size, input logic [7:0] addr,
                                input logic [31:0] wd, input bit apply,
                                output int off_lat, output bit err, output logic [31:0] data);
    int a, nb, sh;
    logic [31:0] w, mask, v;
    a  = int'(addr);
    nb = 1 << size[1:0];
    err = (size[1:0] == 2'b11) || (size == 3'b110) || ((a % nb) != 0) || (we && size[2]);
    sh = (a % 4) * 8;
    w  = mdl[a / 4];
    data = '0;
    off_lat = 0;
    if (err) begin
      off_lat = 0;
    end else if (!we) begin
      off_lat = 1;
      v = w >> sh;
      if (nb == 1) begin
        v = v & 32'h0000_00FF;
        if (!size[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else if (nb == 2) begin
        v = v & 32'h0000_FFFF;
        if (!size[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      data = v;
    end else begin
      off_lat = (nb == 4) ? 1 : 2;
      mask = (nb == 4) ? 32'hFFFF_FFFF : (((32'd1 << (nb * 8)) - 32'd1) << sh);
      if (apply) mdl[a / 4] = (w & ~mask) | ((wd << sh) & mask);
    end
  endfunction

  initial begin
    bit live, ev, er;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) last_rst = cyc;
      #1;
      if (!done) begin
        live = pend && (last_rst < acc);
        ev = live && (cyc == rsp_cyc);
        er = !(live && (cyc <= rsp_cyc));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("rsp_rdata", bus.rsp_rdata, ev ? exp_data : 32'h0);
        if (ev) chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic do_req(input bit we, input logic [2:0] size, input logic [7:0] addr,
                        input logic [31:0] wd, input bit hold,
                        output logic [31:0] got, output bit got_err, output int lat);
    int n, ol;
    bit e;
    logic [31:0] d;
    n = 0;
    while (!bus.req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) chk("ready_timeout", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    model(we, size, addr, wd, 1'b1, ol, e, d);
    exp_err  = e;
    exp_data = d;
    acc      = cyc + 1;
    rsp_cyc  = acc + ol;
    pend     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (hold) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_size  = 3'($urandom_range(0, 7));
        bus.req_addr  = 8'($urandom_range(0, 255));
        bus.req_wdata = $urandom;
      end else begin
        bus.req_valid = 1'b0;
      end
    end while (!bus.rsp_valid && n < 6);
    if (!bus.rsp_valid) chk("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
    got     = bus.rsp_rdata;
    got_err = bus.rsp_err;
    lat     = cyc - acc;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    bit ge;
    int lat, prev_rsp, n;
    logic [2:0] legal [5];
    logic [2:0] sz;
    bit we;
    legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rdata", bus.rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 64; i++) do_req(1'b1, 3'b010, 8'(i * 4), 32'h0, 1'b0, got, ge, lat);

    do_req(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 1'b0, got, ge, lat);
    chk("sw_err", 32'(ge), 32'd0);
    chk("sw_latency", 32'(lat), 32'd1);
    do_req(1'b0, 3'b010, 8'h10, 32'h0, 1'b0, got, ge, lat);
    chk("lw_data", got, 32'hDEADBEEF);
    chk("lw_latency", 32'(lat), 32'd1);
    do_req(1'b1, 3'b000, 8'h11, 32'h00000080, 1'b0, got, ge, lat);
    chk("sb_latency", 32'(lat), 32'd2);
    do_req(1'b0, 3'b010, 8'h10, 32'h0, 1'b0, got, ge, lat);
    chk("lw_after_sb", got, 32'hDEAD80EF);
    do_req(1'b0, 3'b000, 8'h11, 32'h0, 1'b0, got, ge, lat);
    chk("lb_sign", got, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 8'h11, 32'h0, 1'b0, got, ge, lat);
    chk("lbu_zero", got, 32'h00000080);
    do_req(1'b1, 3'b001, 8'h12, 32'h00001234, 1'b0, got, ge, lat);
    do_req(1'b0, 3'b010, 8'h10, 32'h0, 1'b0, got, ge, lat);
    chk("lw_after_sh", got, 32'h123480EF);
    do_req(1'b0, 3'b001, 8'h12, 32'h0, 1'b0, got, ge, lat);
    chk("lh_pos", got, 32'h00001234);
    do_req(1'b1, 3'b001, 8'h12, 32'h00009ABC, 1'b0, got, ge, lat);
    do_req(1'b0, 3'b001, 8'h12, 32'h0, 1'b0, got, ge, lat);
    chk("lh_neg", got, 32'hFFFF9ABC);
    do_req(1'b0, 3'b101, 8'h12, 32'h0, 1'b0, got, ge, lat);
    chk("lhu", got, 32'h00009ABC);

    do_req(1'b0, 3'b010, 8'h11, 32'h0, 1'b0, got, ge, lat);
    chk("lw_mis_err", 32'(ge), 32'd1);
    chk("lw_mis_data", got, 32'd0);
    chk("err_latency", 32'(lat), 32'd0);
    do_req(1'b0, 3'b001, 8'h13, 32'h0, 1'b0, got, ge, lat);
    chk("lh_mis_err", 32'(ge), 32'd1);
    do_req(1'b1, 3'b100, 8'h10, 32'h000000FF, 1'b0, got, ge, lat);
    chk("sbu_err", 32'(ge), 32'd1);
    do_req(1'b0, 3'b010, 8'h10, 32'h0, 1'b0, got, ge, lat);
    chk("word_unchanged", got, 32'h9ABC80EF);

    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      do_req(we, sz, 8'($urandom_range(0, 255)), $urandom, ($urandom_range(0, 3) == 0), got, ge, lat);
      n = $urandom_range(0, 2);
      repeat (n) @(negedge clk);
    end

    do_req(1'b1, 3'b010, 8'h30, $urandom, 1'b1, got, ge, lat);
    for (int i = 0; i < 16; i++) begin
      prev_rsp = rsp_cyc;
      we = i[0];
      sz = legal[$urandom_range(0, 2)];
      do_req(we, sz, 8'($urandom_range(0, 255)), $urandom, 1'b1, got, ge, lat);
      chk("accept_gap", 32'(acc), 32'(prev_rsp + 2));
    end

    do_req(1'b1, 3'b010, 8'h20, 32'h0, 1'b0, got, ge, lat);
    n = 0;
    while (!bus.req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 3'b010;
    bus.req_addr  = 8'h20;
    bus.req_wdata = 32'h11111111;
    begin
      int ol;
      bit e;
      logic [31:0] d;
      model(1'b1, 3'b010, 8'h20, 32'h11111111, 1'b0, ol, e, d);
      exp_err  = e;
      exp_data = d;
      acc      = cyc + 1;
      rsp_cyc  = acc + ol;
      pend     = 1'b1;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("wr_cycle_busy", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    do_req(1'b0, 3'b010, 8'h20, 32'h0, 1'b0, got, ge, lat);
    chk("rst_write_suppressed", got, 32'h00000000);

    repeat (2) @(negedge clk);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
